// File: rtl/branch_predict_resolve.sv
// Conditional branch predictor and resolver beside the EX comparator.
// IF looks up a 2-bit counter table; EX resolves, trains, redirects on mispredict, and counts.
module branch_predict_resolve #(
    parameter int          BHT_ENTRIES = 32,
    parameter logic [1:0]  CTR_INIT    = 2'b01
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] if_pc,
    input  logic [31:0] if_instruction,
    output logic        pred_taken,
    output logic [31:0] pred_target,

    input  logic        ex_valid,
    input  logic [31:0] ex_instruction,
    input  logic [31:0] ex_pc,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_target,
    input  logic        br_lt,
    input  logic        br_eq,

    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [31:0] br_count,
    output logic [31:0] mispred_count
);

    localparam int         IDX_W     = $clog2(BHT_ENTRIES);
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } br_funct3_e;

    function automatic logic is_branch(input logic [31:0] inst);
        logic f3_ok;
        f3_ok = (inst[14:12] != 3'b010) && (inst[14:12] != 3'b011);
        return (inst[6:0] == OP_BRANCH) && f3_ok;
    endfunction

    function automatic logic [31:0] b_imm(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]  bht_q [BHT_ENTRIES];
    logic        redirect_valid_q, redirect_valid_d;
    logic [31:0] redirect_pc_q,    redirect_pc_d;
    logic [31:0] br_count_q,       br_count_d;
    logic [31:0] mispred_count_q,  mispred_count_d;

    // ------------------------------------------------------------------
    // IF lookup: reads the registered table, so an EX update in the same
    // cycle is only seen from the next cycle on.
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] if_idx;
    logic             if_is_branch;

    assign if_idx       = if_pc[IDX_W+1:2];
    assign if_is_branch = is_branch(if_instruction);
    assign pred_taken   = if_is_branch & bht_q[if_idx][1];
    assign pred_target  = if_is_branch ? (if_pc + b_imm(if_instruction)) : (if_pc + 32'd4);

    // ------------------------------------------------------------------
    // EX resolve
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] ex_idx;
    logic             ex_is_branch;
    logic             actual_taken;
    logic             resolve;
    logic             mispredict;
    logic [1:0]       ctr_cur;
    logic [1:0]       ctr_next;

    assign ex_idx       = ex_pc[IDX_W+1:2];
    assign ex_is_branch = is_branch(ex_instruction);

    // NOTE: every signal written in always_comb gets a default before the
    // case, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        actual_taken = 1'b0;
        unique case (ex_instruction[14:12])
            F3_BEQ:           actual_taken = br_eq;
            F3_BNE:           actual_taken = ~br_eq;
            F3_BLT, F3_BLTU:  actual_taken = br_lt;
            F3_BGE, F3_BGEU:  actual_taken = ~br_lt;
            default:          actual_taken = 1'b0;
        endcase
    end

    // The EX instruction during a redirect cycle is on the wrong path.
    assign resolve    = ex_valid & ex_is_branch & ~redirect_valid_q;
    assign mispredict = resolve & (actual_taken != ex_pred_taken);

    always_comb begin
        ctr_cur  = bht_q[ex_idx];
        ctr_next = ctr_cur;
        if (actual_taken) begin
            if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'b01;
        end else begin
            if (ctr_cur != 2'b00) ctr_next = ctr_cur - 2'b01;
        end
    end

    always_comb begin
        redirect_valid_d = mispredict;
        redirect_pc_d    = redirect_pc_q;
        br_count_d       = br_count_q;
        mispred_count_d  = mispred_count_q;
        if (resolve && (br_count_q != 32'hFFFF_FFFF)) begin
            br_count_d = br_count_q + 32'd1;
        end
        if (mispredict) begin
            redirect_pc_d = actual_taken ? ex_target : (ex_pc + 32'd4);
            if (mispred_count_q != 32'hFFFF_FFFF) begin
                mispred_count_d = mispred_count_q + 32'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    // NOTE: the counter table is built from flops, not RAM, so it can and
    // must be cleared by reset like any other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= CTR_INIT;
            end
        end else if (resolve) begin
            bht_q[ex_idx] <= ctr_next;
        end
    end

    // NOTE: non-blocking assignments for all clocked state, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
            br_count_q       <= 32'd0;
            mispred_count_q  <= 32'd0;
        end else begin
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            br_count_q       <= br_count_d;
            mispred_count_q  <= mispred_count_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign br_count       = br_count_q;
    assign mispred_count  = mispred_count_q;

    // Register-field bits that only the register file and ALU care about.
    logic unused_inst_bits;
    assign unused_inst_bits = ^{if_instruction[24:15], ex_instruction[31:15], ex_instruction[11:7]};

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Randomized self-checking bench for branch_predict_resolve against a behavioural model.
// Directed scenarios first, then random traffic over aliasing PCs.
module tb_branch_predict_resolve;

    localparam int N_ENT = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc, if_instruction, pred_target;
    logic        pred_taken;
    logic        ex_valid, ex_pred_taken, br_lt, br_eq;
    logic [31:0] ex_instruction, ex_pc, ex_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc, br_count, mispred_count;

    branch_predict_resolve #(.BHT_ENTRIES(N_ENT), .CTR_INIT(2'b01)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_pc          (if_pc),
        .if_instruction (if_instruction),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_instruction (ex_instruction),
        .ex_pc          (ex_pc),
        .ex_pred_taken  (ex_pred_taken),
        .ex_target      (ex_target),
        .br_lt          (br_lt),
        .br_eq          (br_eq),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .br_count       (br_count),
        .mispred_count  (mispred_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_ctr [N_ENT];
    longint      m_brc, m_mpc;
    bit          m_rv;
    logic [31:0] m_rpc;
    bit          m_after_rst;

    function automatic bit m_is_br(input logic [31:0] inst);
        int op, f3;
        op = int'(inst & 32'h7f);
        f3 = int'((inst >> 12) & 32'h7);
        return (op == 99) && (f3 != 2) && (f3 != 3);
    endfunction

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc >> 2) % N_ENT);
    endfunction

    function automatic int m_imm(input logic [31:0] inst);
        int v;
        v = int'(((inst >> 31) & 1) << 12) + int'(((inst >> 7) & 1) << 11)
          + int'(((inst >> 25) & 63) << 5) + int'(((inst >> 8) & 15) << 1);
        if (v >= 4096) v = v - 8192;
        return v;
    endfunction

    function automatic bit m_pred(input logic [31:0] pc, input logic [31:0] inst);
        return m_is_br(inst) && (m_ctr[m_idx(pc)] >= 2);
    endfunction

    function automatic logic [31:0] mk_br(input logic [2:0] f3, input int imm);
        logic [12:0] im;
        im = imm[12:0];
        return {im[12], im[10:5], 5'd2, 5'd1, f3, im[4:1], im[11], 7'h63};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_ENT; i++) m_ctr[i] = 1;
        m_brc = 0; m_mpc = 0; m_rv = 0; m_rpc = 32'd0; m_after_rst = 1;
    endtask

    // One clock: drive at negedge, check just after, advance model at posedge.
    task automatic cycle(input logic [31:0] ipc, input logic [31:0] iinst, input logic ev,
                         input logic [31:0] einst, input logic [31:0] epc, input logic ept,
                         input logic [31:0] etgt, input logic lt, input logic eq, input logic r);
        bit          n_rv, taken;
        logic [31:0] n_rpc, exp_tgt;
        int          f3, k;
        if_pc = ipc; if_instruction = iinst; ex_valid = ev; ex_instruction = einst;
        ex_pc = epc; ex_pred_taken = ept; ex_target = etgt; br_lt = lt; br_eq = eq; rst = r;
        #1;
        exp_tgt = m_is_br(iinst) ? ipc + 32'(m_imm(iinst)) : ipc + 32'd4;
        check("pred_taken", {31'd0, pred_taken}, {31'd0, m_pred(ipc, iinst)});
        check("pred_target", pred_target, exp_tgt);
        check("redirect_valid", {31'd0, redirect_valid}, {31'd0, m_rv});
        if (m_rv || m_after_rst) check("redirect_pc", redirect_pc, m_rpc);
        check("br_count", br_count, m_brc[31:0]);
        check("mispred_count", mispred_count, m_mpc[31:0]);
        n_rv = 0; n_rpc = m_rpc;
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            m_after_rst = 0;
            if (ev && m_is_br(einst) && !m_rv) begin
                f3 = int'((einst >> 12) & 32'h7);
                case (f3)
                    0: taken = eq;
                    1: taken = !eq;
                    4, 6: taken = lt;
                    default: taken = !lt;
                endcase
                k = m_idx(epc);
                m_ctr[k] = taken ? ((m_ctr[k] < 3) ? m_ctr[k] + 1 : 3)
                                 : ((m_ctr[k] > 0) ? m_ctr[k] - 1 : 0);
                if (m_brc < 64'hFFFF_FFFF) m_brc++;
                if (taken != ept) begin
                    if (m_mpc < 64'hFFFF_FFFF) m_mpc++;
                    n_rv  = 1;
                    n_rpc = taken ? etgt : epc + 32'd4;
                end
            end
            m_rv = n_rv; m_rpc = n_rpc;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(32'h0, 32'h13, 1'b0, 32'h13, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    logic [31:0] beq16, bne8, bge8, bltu, f3_010, ipc, iinst, einst, epc, etgt;
    longint      brc_snap;
    bit          ept;

    initial begin
        beq16  = mk_br(3'b000, 16);
        bne8   = mk_br(3'b001, 8);
        bge8   = mk_br(3'b101, 8);
        bltu   = mk_br(3'b110, -4);
        f3_010 = mk_br(3'b010, 8);

        rst = 1'b1; if_pc = 0; if_instruction = 32'h13; ex_valid = 0; ex_instruction = 32'h13;
        ex_pc = 0; ex_pred_taken = 0; ex_target = 0; br_lt = 0; br_eq = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();

        // 1: reset state and first lookup
        cycle(32'h100, beq16, 0, 32'h13, 0, 0, 0, 0, 0, 0);
        check("t1_pred_target_const", pred_target, 32'h110);

        // 2: BEQ resolves taken, predicted not taken
        cycle(32'h0, 32'h13, 1, beq16, 32'h100, 0, 32'h110, 0, 1, 0);
        check("t2_redirect_pc_const", redirect_pc, 32'h110);
        cycle(32'h100, beq16, 0, 32'h13, 0, 0, 0, 0, 0, 0);
        check("t2_trained_pred", {31'd0, pred_taken}, 32'd1);
        idle();

        // 3: train BNE at 0x200 to saturation, then a mispredicted BGE
        for (int i = 0; i < 5; i++) begin
            ept = m_pred(32'h200, bne8);
            cycle(32'h200, bne8, 1, bne8, 32'h200, ept, 32'h208, 0, 0, 0);
            if (m_rv) idle();
        end
        check("t3_saturated", {30'd0, 2'(m_ctr[m_idx(32'h200)])}, 32'd3);
        cycle(32'h200, bge8, 1, bge8, 32'h200, 1, 32'h208, 1, 0, 0);

        // 4: the instruction right after a mispredict is squashed
        brc_snap = m_brc;
        cycle(32'h200, bge8, 1, bltu, 32'h200, 0, 32'h1FC, 1, 0, 0);
        check("t3_redirect_pc_const", redirect_pc, 32'h204);
        cycle(32'h200, bge8, 0, 32'h13, 0, 0, 0, 0, 0, 0);
        check("t4_squash_count", br_count, brc_snap[31:0]);

        // 5: IF and EX hit the same entry in one cycle; then funct3=010 in EX
        cycle(32'h300, beq16, 1, beq16, 32'h300, 0, 32'h310, 0, 1, 0);
        cycle(32'h300, beq16, 0, 32'h13, 0, 0, 0, 0, 0, 0);
        brc_snap = m_brc;
        cycle(32'h300, beq16, 1, f3_010, 32'h300, 0, 32'h310, 1, 1, 0);
        cycle(32'h300, beq16, 0, 32'h13, 0, 0, 0, 0, 0, 0);
        check("t5_f3_010_nocount", br_count, brc_snap[31:0]);

        // 6: counter saturation via backdoor, then reset during a mispredict
        dut.br_count_q      = 32'hFFFF_FFFE; m_brc = 64'hFFFF_FFFE;
        dut.mispred_count_q = 32'hFFFF_FFFF; m_mpc = 64'hFFFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            cycle(32'h0, 32'h13, 1, bne8, 32'h200, 0, 32'h208, 0, 0, 0);
            idle();
        end
        check("t6_br_sat", br_count, 32'hFFFF_FFFF);
        check("t6_mp_sat", mispred_count, 32'hFFFF_FFFF);
        cycle(32'h0, 32'h13, 1, beq16, 32'h100, 0, 32'h110, 0, 1, 1);
        for (int i = 0; i < N_ENT; i++) begin
            cycle(32'(i * 4), beq16, 0, 32'h13, 0, 0, 0, 0, 0, 0);
        end

        // random traffic over 64 PCs aliasing onto 32 entries
        for (int n = 0; n < 3000; n++) begin
            ipc  = 32'h1000 + (32'($urandom_range(0, 63)) << 2);
            epc  = 32'h1000 + (32'($urandom_range(0, 63)) << 2);
            iinst = ($urandom_range(0, 9) < 8) ? mk_br(3'($urandom), int'($urandom_range(0, 8191)) - 4096)
                                               : $urandom;
            einst = ($urandom_range(0, 9) < 8) ? mk_br(3'($urandom), int'($urandom_range(0, 8191)) - 4096)
                                               : $urandom;
            ept  = ($urandom_range(0, 3) != 0) ? m_pred(epc, einst) : 1'($urandom);
            etgt = epc + 32'(m_imm(einst));
            cycle(ipc, iinst, ($urandom_range(0, 4) != 0), einst, epc, ept, etgt,
                  1'($urandom), 1'($urandom), ($urandom_range(0, 199) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
